// File: rtl/fft_bitrev_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_bitrev_loader
// Description : Input stage for a radix-2 FFT. Real signed samples arrive
//               over a valid/ready stream and are stored at their
//               bit-reversed addresses. The stored frame is then streamed out
//               as first-stage butterfly operand pairs (even/odd, real/imag).
//
// Parameters  : SAMPLE_SIZE - width of signed samples in and out
//               FFT_POINTS  - frame length (power of two, >= 4)
//               ADDR_W      - derived address width, leave at default
//
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               in_sample         - signed input sample
//               in_valid/in_ready - input handshake (ready only while filling)
//               pair_even_real    - even operand mem[2p]
//               pair_odd_real     - odd operand  mem[2p+1]
//               pair_even_imag    - constant 0 (real input)
//               pair_odd_imag     - constant 0 (real input)
//               pair_index        - pair number p
//               pair_valid/pair_ready - output handshake
//               frame_done        - one-cycle pulse after the last pair
//
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_loader #(
    parameter int SAMPLE_SIZE = 16,
    parameter int FFT_POINTS  = 16,
    parameter int ADDR_W      = $clog2(FFT_POINTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [SAMPLE_SIZE-1:0] in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [SAMPLE_SIZE-1:0] pair_even_real,
    output logic signed [SAMPLE_SIZE-1:0] pair_odd_real,
    output logic signed [SAMPLE_SIZE-1:0] pair_even_imag,
    output logic signed [SAMPLE_SIZE-1:0] pair_odd_imag,
    output logic        [ADDR_W-2:0]      pair_index,
    output logic                          pair_valid,
    input  logic                          pair_ready,
    output logic                          frame_done
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] WR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-2:0] RD_LAST = {(ADDR_W-1){1'b1}};

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                          state_q,          state_d;
    logic        [ADDR_W-1:0]        wr_cnt_q,         wr_cnt_d;
    logic        [ADDR_W-2:0]        rd_cnt_q,         rd_cnt_d;
    logic signed [SAMPLE_SIZE-1:0]   even_q,           even_d;
    logic signed [SAMPLE_SIZE-1:0]   odd_q,            odd_d;
    logic        [ADDR_W-2:0]        index_q,          index_d;
    logic                            pair_valid_q,     pair_valid_d;
    logic                            frame_done_q,     frame_done_d;

    // Sample storage; contents are never reset because a new frame fully
    // overwrites every entry before any of it is read back out.
    logic signed [SAMPLE_SIZE-1:0]   mem_q [FFT_POINTS];

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic                w_accept;
    logic                w_wr_last;
    logic                w_pair_fire;
    logic                w_pair_last;
    logic [ADDR_W-2:0]   w_rd_next;
    logic [ADDR_W-2:0]   w_load_idx;
    logic [ADDR_W-1:0]   w_even_addr;
    logic [ADDR_W-1:0]   w_odd_addr;
    logic [ADDR_W-1:0]   w_wr_addr;

    // in_ready depends on the state register only, never on in_valid.
    assign in_ready    = (state_q == ST_FILL);

    assign w_accept    = in_valid && in_ready;
    assign w_wr_last   = w_accept && (wr_cnt_q == WR_LAST);
    assign w_pair_fire = pair_valid_q && pair_ready;
    assign w_pair_last = w_pair_fire && (rd_cnt_q == RD_LAST);
    assign w_rd_next   = rd_cnt_q + (ADDR_W-1)'(1);

    // On the FILL->DRAIN edge pair 0 is loaded; in DRAIN the next pair.
    // Pair 0 reads mem[0] and mem[1] (samples 0 and N/2), both written well
    // before the final sample, which lands at mem[N-1].
    assign w_load_idx  = (state_q == ST_FILL) ? '0 : w_rd_next;
    assign w_even_addr = {w_load_idx, 1'b0};
    assign w_odd_addr  = {w_load_idx, 1'b1};
    assign w_wr_addr   = bitrev(wr_cnt_q);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        even_d       = even_q;
        odd_d        = odd_q;
        index_d      = index_q;
        pair_valid_d = pair_valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (w_accept) begin
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    if (w_wr_last) begin
                        wr_cnt_d     = '0;
                        state_d      = ST_DRAIN;
                        even_d       = mem_q[w_even_addr];
                        odd_d        = mem_q[w_odd_addr];
                        index_d      = w_load_idx;
                        pair_valid_d = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (w_pair_last) begin
                    rd_cnt_d     = '0;
                    pair_valid_d = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = ST_FILL;
                end else if (w_pair_fire) begin
                    // Next pair is loaded on the handshake edge: no bubble.
                    rd_cnt_d = w_rd_next;
                    even_d   = mem_q[w_even_addr];
                    odd_d    = mem_q[w_odd_addr];
                    index_d  = w_load_idx;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            even_q       <= '0;
            odd_q        <= '0;
            index_q      <= '0;
            pair_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            even_q       <= even_d;
            odd_q        <= odd_d;
            index_q      <= index_d;
            pair_valid_q <= pair_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Sample storage write port (bit-reversed address)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[w_wr_addr] <= in_sample;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pair_even_real = even_q;
    assign pair_odd_real  = odd_q;
    assign pair_even_imag = '0;
    assign pair_odd_imag  = '0;
    assign pair_index     = index_q;
    assign pair_valid     = pair_valid_q;
    assign frame_done     = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bitrev_loader
// Description : Self-checking bench for fft_bitrev_loader (8-point frames).
//               Expected pairs come from a reference model: operand k of the
//               frame is the sample whose index is the bit reversal of k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_loader;

    localparam int SS = 16;
    localparam int N  = 8;
    localparam int AW = $clog2(N);
    localparam int NP = N / 2;

    logic                 clk;
    logic                 rst_n;
    logic signed [SS-1:0] in_sample;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [SS-1:0] pair_even_real;
    logic signed [SS-1:0] pair_odd_real;
    logic signed [SS-1:0] pair_even_imag;
    logic signed [SS-1:0] pair_odd_imag;
    logic        [AW-2:0] pair_index;
    logic                 pair_valid;
    logic                 pair_ready;
    logic                 frame_done;

    int total = 0;
    int bad   = 0;

    logic signed [SS-1:0] frame [N];
    logic signed [SS-1:0] nxt   [N];

    fft_bitrev_loader #(
        .SAMPLE_SIZE (SS),
        .FFT_POINTS  (N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_sample      (in_sample),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pair_even_real (pair_even_real),
        .pair_odd_real  (pair_odd_real),
        .pair_even_imag (pair_even_imag),
        .pair_odd_imag  (pair_odd_imag),
        .pair_index     (pair_index),
        .pair_valid     (pair_valid),
        .pair_ready     (pair_ready),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arithmetic bit reversal of an AW-bit index.
    function automatic int rev(input int i);
        int r;
        int v;
        r = 0;
        v = i;
        for (int b = 0; b < AW; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Drive samples frame[first..last-1]; gap_mode 0: none, 1: one idle
    // cycle between samples, 2: random 0..2 idle cycles.
    task automatic send_frame(input int first, input int last, input int gap_mode);
        for (int i = first; i < last; i++) begin
            int gaps;
            gaps = 0;
            if (i > first) begin
                if (gap_mode == 1) gaps = 1;
                else if (gap_mode == 2) gaps = $urandom_range(0, 2);
            end
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                in_valid  = 1'b0;
                in_sample = SS'($urandom);
            end
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1 || pair_valid !== 1'b0) begin
                bad++;
                $display("FAIL fill_ctl sample %0d: in_ready=%b pair_valid=%b, required 1 0",
                         i, in_ready, pair_valid);
            end
            in_valid  = 1'b1;
            in_sample = frame[i];
        end
    endtask

    // Drain the current frame. stall_pair gets stall_cycles cycles with
    // pair_ready low first. junk drives in_valid during drain. chain offers
    // nxt[0] in the frame_done cycle. abort_pair < NP returns after observing
    // that pair without consuming it.
    task automatic drain_frame(input int stall_pair, input int stall_cycles,
                               input bit junk, input bit chain, input int abort_pair);
        for (int p = 0; p < NP; p++) begin
            int stalls;
            logic [AW-2:0] pi;
            logic signed [SS-1:0] exp_e;
            logic signed [SS-1:0] exp_o;
            stalls = (p == stall_pair) ? stall_cycles : 0;
            pi     = p[AW-2:0];
            exp_e  = frame[rev(2 * p)];
            exp_o  = frame[rev(2 * p + 1)];
            for (int s = 0; s <= stalls; s++) begin
                @(negedge clk);
                in_valid  = junk;
                in_sample = SS'($urandom);
                total++;
                if (pair_valid !== 1'b1 || pair_index !== pi) begin
                    bad++;
                    $display("FAIL pair_ctl p=%0d: valid=%b index=%0d, required 1 %0d",
                             p, pair_valid, pair_index, p);
                end
                total++;
                if (pair_even_real !== exp_e || pair_odd_real !== exp_o) begin
                    bad++;
                    $display("FAIL pair_data p=%0d: got (%0d,%0d), required (%0d,%0d)",
                             p, pair_even_real, pair_odd_real, exp_e, exp_o);
                end
                total++;
                if (pair_even_imag !== '0 || pair_odd_imag !== '0 ||
                    in_ready !== 1'b0 || frame_done !== 1'b0) begin
                    bad++;
                    $display("FAIL pair_misc p=%0d: imag=(%0d,%0d) in_ready=%b done=%b, required 0 0 0 0",
                             p, pair_even_imag, pair_odd_imag, in_ready, frame_done);
                end
                if (p == abort_pair) begin
                    pair_ready = 1'b0;
                    return;
                end
                pair_ready = (s == stalls);
            end
        end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b1 || pair_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL frame_end: done=%b valid=%b in_ready=%b, required 1 0 1",
                     frame_done, pair_valid, in_ready);
        end
        pair_ready = 1'b0;
        if (chain) begin
            in_valid  = 1'b1;
            in_sample = nxt[0];
        end else begin
            in_valid = 1'b0;
            @(negedge clk);
            total++;
            if (frame_done !== 1'b0 || pair_valid !== 1'b0) begin
                bad++;
                $display("FAIL done_pulse: done=%b valid=%b, required 0 0",
                         frame_done, pair_valid);
            end
        end
    endtask

    // Asserts reset mid-cycle and checks the outputs clear at once.
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (pair_valid !== 1'b0 || frame_done !== 1'b0 || pair_index !== '0 ||
            pair_even_real !== '0 || pair_odd_real !== '0 ||
            pair_even_imag !== '0 || pair_odd_imag !== '0) begin
            bad++;
            $display("FAIL %s: valid=%b done=%b index=%0d data=(%0d,%0d,%0d,%0d), required all 0",
                     tag, pair_valid, frame_done, pair_index, pair_even_real,
                     pair_odd_real, pair_even_imag, pair_odd_imag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || pair_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: in_ready=%b valid=%b, required 1 0",
                     tag, in_ready, pair_valid);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) frame[i] = SS'($urandom);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (pair_valid !== 1'b0 || frame_done !== 1'b0 || pair_index !== '0 ||
            pair_even_real !== '0 || pair_odd_real !== '0) begin
            bad++;
            $display("FAIL reset_values: valid=%b done=%b index=%0d data=(%0d,%0d), required all 0",
                     pair_valid, frame_done, pair_index, pair_even_real, pair_odd_real);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_ordering();
        for (int i = 0; i < N; i++) frame[i] = SS'(10 + i);
        send_frame(0, N, 0);
        drain_frame(-1, 0, 1'b0, 1'b0, NP);
    endtask

    task automatic test_sign_imag();
        for (int i = 0; i < N; i++) begin
            case (i % 4)
                0:       frame[i] = 16'hFFFF;
                1:       frame[i] = 16'h8000;
                2:       frame[i] = 16'h7FFF;
                default: frame[i] = 16'h0000;
            endcase
        end
        send_frame(0, N, 0);
        drain_frame(-1, 0, 1'b0, 1'b0, NP);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) frame[i] = SS'(10 + i);
        send_frame(0, N, 0);
        drain_frame(1, 3, 1'b0, 1'b0, NP);
    endtask

    task automatic test_gaps_drain_input();
        for (int i = 0; i < N; i++) frame[i] = SS'(10 + i);
        send_frame(0, N, 1);
        drain_frame(-1, 0, 1'b1, 1'b0, NP);
        fill_random();
        send_frame(0, N, 0);
        drain_frame(-1, 0, 1'b0, 1'b0, NP);
    endtask

    task automatic test_reset_mid_fill();
        fill_random();
        send_frame(0, 5, 0);
        @(negedge clk);
        in_valid = 1'b0;
        pulse_reset("reset_mid_fill");
        for (int i = 0; i < N; i++) frame[i] = SS'(20 + i);
        send_frame(0, N, 0);
        drain_frame(-1, 0, 1'b0, 1'b0, NP);
    endtask

    task automatic test_reset_mid_drain();
        fill_random();
        send_frame(0, N, 0);
        drain_frame(-1, 0, 1'b0, 1'b0, 2);
        in_valid = 1'b0;
        pulse_reset("reset_mid_drain");
        fill_random();
        send_frame(0, N, 2);
        drain_frame(-1, 0, 1'b0, 1'b0, NP);
    endtask

    task automatic test_back_to_back();
        fill_random();
        for (int i = 0; i < N; i++) nxt[i] = SS'($urandom);
        send_frame(0, N, 0);
        drain_frame(-1, 0, 1'b0, 1'b1, NP);
        for (int i = 0; i < N; i++) frame[i] = nxt[i];
        send_frame(1, N, 0);
        drain_frame(-1, 0, 1'b0, 1'b0, NP);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            fill_random();
            send_frame(0, N, 2);
            drain_frame($urandom_range(0, NP - 1), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'b0, NP);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sample  = '0;
        pair_ready = 1'b0;
        test_reset();
        test_ordering();
        test_sign_imag();
        test_backpressure();
        test_gaps_drain_input();
        test_reset_mid_fill();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
